// File: rtl/mult_hilo_unit.sv
`timescale 1ns/1ps
// mult_hilo_unit
// Multi-cycle unsigned multiply / multiply-accumulate unit holding the
// architectural HI/LO pair. Handles MULTU ({hi,lo} = a*b) and MADDU
// ({hi,lo} += a*b) with a radix-2 shift-add datapath, one multiplier bit per
// clock, so every operation takes exactly WIDTH cycles. The pipeline hazard
// logic stalls on busy; HI/LO only change on the final iteration, so readers
// never see a partial product.
module mult_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,      // asynchronous, active-low
  input  logic             start,
  input  logic             acc,
  input  logic             flush,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // One shift-add step: add the multiplicand when the current multiplier bit is set.
  function automatic logic [PW-1:0] shift_add_step(
    input logic [PW-1:0] partial,
    input logic [PW-1:0] mcand,
    input logic          mbit
  );
    shift_add_step = mbit ? (partial + mcand) : partial;
  endfunction

  // Final write-back value: plain product for MULTU, wrapped sum for MADDU.
  function automatic logic [PW-1:0] hilo_result(
    input logic [PW-1:0] hilo,
    input logic [PW-1:0] product,
    input logic          accumulate
  );
    hilo_result = accumulate ? (hilo + product) : product;
  endfunction

  state_t           state_q,   state_d;
  logic [PW-1:0]    mcand_q,   mcand_d;
  logic [WIDTH-1:0] mplier_q,  mplier_d;
  logic [PW-1:0]    partial_q, partial_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             acc_q,     acc_d;
  logic [PW-1:0]    hilo_q,    hilo_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic [PW-1:0]    step_sum;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    partial_d = partial_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    hilo_d    = hilo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    step_sum  = shift_add_step(partial_q, mcand_q, mplier_q[0]);

    case (state_q)
      S_IDLE: begin
        // flush squashes a simultaneous issue
        if (start && !flush) begin
          mcand_d   = {{WIDTH{1'b0}}, src_a};
          mplier_d  = src_b;
          partial_d = '0;
          cnt_d     = '0;
          acc_d     = acc;
          busy_d    = 1'b1;
          state_d   = S_RUN;
        end
      end

      S_RUN: begin
        if (flush) begin
          // abandon the operation; HI/LO keep their pre-issue values
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          partial_d = step_sum;
          mcand_d   = mcand_q << 1;
          mplier_d  = mplier_q >> 1;
          cnt_d     = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            hilo_d  = hilo_result(hilo_q, step_sum, acc_q);
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything including HI/LO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      partial_q <= '0;
      cnt_q     <= '0;
      acc_q     <= 1'b0;
      hilo_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      partial_q <= partial_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      hilo_q    <= hilo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hilo_q[PW-1:WIDTH];
  assign lo   = hilo_q[WIDTH-1:0];

endmodule

// File: tb/tb_mult_hilo_unit.sv
`timescale 1ns/1ps
// Testbench for mult_hilo_unit: directed table of MULTU/MADDU chains, hand
// sequences for reset/flush/ignored-start corners, then random operations
// checked against a 64-bit arithmetic model of HI/LO.
module tb_mult_hilo_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         acc = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] model = 64'd0;

  typedef struct {
    logic        acc;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[8];

  mult_hilo_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .acc   (acc),
    .flush (flush),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one op at the current negedge, follow it to completion and check it.
  // spur_cyc > 0 pulses start with other operands in that busy cycle.
  task automatic run_op(input string name, input logic acc_i, input logic [31:0] a_i,
                        input logic [31:0] b_i, input logic [63:0] exp, input int spur_cyc);
    logic [63:0] prev;
    int          cyc;
    logic        hold_ok;
    logic        overlap;
    prev    = {hi, lo};
    start   = 1'b1;
    acc     = acc_i;
    src_a   = a_i;
    src_b   = b_i;
    step();
    start   = 1'b0;
    cyc     = 0;
    hold_ok = 1'b1;
    overlap = 1'b0;
    while (busy && cyc < 100) begin
      cyc++;
      if ({hi, lo} !== prev) hold_ok = 1'b0;
      if (done) overlap = 1'b1;
      if (cyc == spur_cyc) begin
        start = 1'b1;
        acc   = 1'b1;
        src_a = 32'h0000_1234;
        src_b = 32'h0000_5678;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    chk({name, " busy_cycles"}, 64'(cyc), 64'(W));
    chk({name, " done"}, {63'd0, done}, 64'd1);
    chk({name, " hilo"}, {hi, lo}, exp);
    chk({name, " hold_during_run"}, {63'd0, hold_ok}, 64'd1);
    chk({name, " done_busy_overlap"}, {63'd0, overlap}, 64'd0);
    model = exp;
  endtask

  initial begin
    logic [63:0] prev;
    logic        seen_done;
    logic        racc;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [63:0] rexp;

    tbl[0] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    tbl[1] = '{1'b1, 32'h0000_0001, 32'h0000_0002, 64'hFFFF_FFFE_0000_0003};
    tbl[2] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    tbl[3] = '{1'b1, 32'h0000_0002, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[4] = '{1'b1, 32'h0000_0001, 32'h0000_0001, 64'h0000_0000_0000_0000};
    tbl[5] = '{1'b0, 32'h0000_0002, 32'h0000_0002, 64'h0000_0000_0000_0004};
    tbl[6] = '{1'b1, 32'h0000_0003, 32'h0000_0003, 64'h0000_0000_0000_000D};
    tbl[7] = '{1'b0, 32'h0000_0000, 32'h1234_5678, 64'h0000_0000_0000_0000};

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset done", {63'd0, done}, 64'd0);
    chk("reset hilo", {hi, lo}, 64'd0);
    rst = 1'b1;
    step();

    // directed table, issued back-to-back (each start lands in the done cycle)
    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("tbl%0d", i), tbl[i].acc, tbl[i].a, tbl[i].b, tbl[i].exp, 0);
    end
    step();
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    chk("idle_busy", {63'd0, busy}, 64'd0);

    // start pulsed during RUN with other operands is ignored
    run_op("multu7x6_spur", 1'b0, 32'd7, 32'd6, 64'd42, 5);
    step();

    // flush mid-RUN of a MADDU: no done, HI/LO unchanged
    run_op("preload", 1'b0, 32'h0001_0001, 32'h0000_0100, 64'h0000_0000_0100_0100, 0);
    step();
    prev  = {hi, lo};
    start = 1'b1; acc = 1'b1; src_a = 32'd1000; src_b = 32'd1000;
    step();
    start = 1'b0;
    for (int i = 1; i < 10; i++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush busy", {63'd0, busy}, 64'd0);
    chk("flush done", {63'd0, done}, 64'd0);
    chk("flush hilo", {hi, lo}, prev);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) seen_done = 1'b1;
      step();
    end
    chk("flush no_late_done", {63'd0, seen_done}, 64'd0);

    // flush and start together in IDLE: nothing issued
    start = 1'b1; flush = 1'b1; acc = 1'b0; src_a = 32'd9; src_b = 32'd9;
    step();
    start = 1'b0; flush = 1'b0;
    chk("flush_start busy", {63'd0, busy}, 64'd0);
    step();
    chk("flush_start hilo", {hi, lo}, prev);

    // flush alone in IDLE has no effect; next op still works
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("idle_flush hilo", {hi, lo}, prev);
    run_op("after_flush_maddu", 1'b1, 32'd5, 32'd4, prev + 64'd20, 0);
    step();

    // asynchronous reset in the middle of RUN
    start = 1'b1; acc = 1'b0; src_a = 32'hDEAD_BEEF; src_b = 32'h1234_5678;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    rst = 1'b0;
    #1;
    chk("midrun_reset busy", {63'd0, busy}, 64'd0);
    chk("midrun_reset done", {63'd0, done}, 64'd0);
    chk("midrun_reset hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst   = 1'b1;
    model = 64'd0;
    step();
    run_op("after_reset_maddu", 1'b1, 32'd7, 32'd6, 64'd42, 0);

    // random ops against the arithmetic model, with occasional idle gaps
    for (int i = 0; i < 16; i++) begin
      racc = 1'($urandom_range(0, 1));
      ra   = $urandom;
      rb   = $urandom;
      if (i % 5 == 0) ra = 32'hFFFF_FFFF;
      rexp = racc ? (model + 64'(ra) * 64'(rb)) : (64'(ra) * 64'(rb));
      run_op($sformatf("rand%0d", i), racc, ra, rb, rexp, 0);
      if ($urandom_range(0, 2) == 0) begin
        for (int g = 0; g < 3; g++) step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
